// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and default widths for the wide-ALU operand loader.
// Optional build macro: ALU_LOADER_UNARY_SKIP_EN (PARITY/POPCOUNT skip the B operand).
package alu_pkg;
  localparam int DATA_WIDTH_DEF = 1024;
  localparam int WORD_WIDTH_DEF = 32;

  localparam logic [2:0] PARITY   = 3'b000;
  localparam logic [2:0] POPCOUNT = 3'b001;
  localparam logic [2:0] ROTR     = 3'b010;
  localparam logic [2:0] ROTL     = 3'b011;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, DRAIN} state_t;

`ifdef ALU_LOADER_UNARY_SKIP_EN
  localparam bit UNARY_SKIP = 1'b1;
`else
  localparam bit UNARY_SKIP = 1'b0;
`endif

  // True when this opcode carries only an A operand in the current build.
  function automatic logic skips_b(input logic [2:0] op);
    return UNARY_SKIP && ((op == PARITY) || (op == POPCOUNT));
  endfunction
endpackage

// File: rtl/alu_operand_loader_buffer.sv
// DATA_WIDTH register viewed as BEATS words: indexed word write, full-width load,
// indexed word read. Word k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
module wide_word_buffer #(
  parameter int DATA_WIDTH = 1024,
  parameter int WORD_WIDTH = 32,
  parameter int BEATS      = DATA_WIDTH / WORD_WIDTH,
  parameter int IW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [IW-1:0]         wr_idx_i,
  input  logic [WORD_WIDTH-1:0] wr_word_i,
  input  logic                  ld_en_i,
  input  logic [DATA_WIDTH-1:0] ld_data_i,
  input  logic [IW-1:0]         rd_idx_i,
  output logic [WORD_WIDTH-1:0] rd_word_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic [BEATS-1:0][WORD_WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          data_q <= '0;
    else if (clr_i)   data_q <= '0;
    else if (ld_en_i) data_q <= ld_data_i;
    else if (wr_en_i) data_q[wr_idx_i] <= wr_word_i;
  end

  assign data_o    = data_q;
  assign rd_word_o = data_q[rd_idx_i];
endmodule

// File: rtl/alu_operand_loader.sv
// Narrow-stream front end for the wide ALU: gathers A/B operands word by word, waits
// ALU_LATENCY, then streams the result back. Macro ALU_LOADER_UNARY_SKIP_EN drops B for unary ops.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int WORD_WIDTH  = WORD_WIDTH_DEF,
  parameter int ALU_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_opcode,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [2:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result
);
  localparam int BEATS = DATA_WIDTH / WORD_WIDTH;
  localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(ALU_LATENCY + 2);
  localparam logic [IW-1:0] LAST_BEAT = IW'(BEATS - 1);
  localparam logic [CW-1:0] LAT_CNT   = CW'(ALU_LATENCY);

  state_t          state_q;
  logic [IW-1:0]   beat_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      opcode_q;

  logic in_hs, out_hs, a_wr, b_wr, b_clr, res_ld, skip_b;
  logic [WORD_WIDTH-1:0] res_word;
  logic [WORD_WIDTH-1:0] a_rd_unused, b_rd_unused;
  logic [DATA_WIDTH-1:0] res_full_unused;

  assign in_ready  = (state_q == IDLE) || (state_q == LOAD_A) || (state_q == LOAD_B);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign skip_b    = skips_b(opcode_q);

  // beat_q is 0 in IDLE, so it doubles as the A write index for the first word.
  assign a_wr   = in_hs && ((state_q == IDLE) || (state_q == LOAD_A));
  assign b_wr   = in_hs && (state_q == LOAD_B);
  assign b_clr  = in_hs && (state_q == IDLE) && skips_b(in_opcode);
  assign res_ld = (state_q == EXEC) && (cnt_q == LAT_CNT);

  assign alu_opcode = opcode_q;
  assign out_data   = out_valid ? res_word : '0;
  assign out_last   = out_valid && (beat_q == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      cnt_q    <= '0;
      opcode_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_hs) begin
          opcode_q <= in_opcode;
          beat_q   <= IW'(1);
          state_q  <= LOAD_A;
        end
        LOAD_A: if (in_hs) begin
          if (beat_q == LAST_BEAT) begin
            beat_q  <= '0;
            cnt_q   <= '0;
            state_q <= skip_b ? EXEC : LOAD_B;
          end else beat_q <= beat_q + 1'b1;
        end
        LOAD_B: if (in_hs) begin
          if (beat_q == LAST_BEAT) begin
            beat_q  <= '0;
            cnt_q   <= '0;
            state_q <= EXEC;
          end else beat_q <= beat_q + 1'b1;
        end
        EXEC: begin
          if (cnt_q == LAT_CNT) begin
            beat_q  <= '0;
            state_q <= DRAIN;
          end else cnt_q <= cnt_q + 1'b1;
        end
        DRAIN: if (out_hs) begin
          if (beat_q == LAST_BEAT) begin
            beat_q  <= '0;
            state_q <= IDLE;
          end else beat_q <= beat_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  wide_word_buffer #(.DATA_WIDTH(DATA_WIDTH), .WORD_WIDTH(WORD_WIDTH)) u_a_buf (
    .clk, .rst, .clr_i(1'b0), .wr_en_i(a_wr), .wr_idx_i(beat_q), .wr_word_i(in_data),
    .ld_en_i(1'b0), .ld_data_i('0), .rd_idx_i('0), .rd_word_o(a_rd_unused), .data_o(alu_a)
  );

  wide_word_buffer #(.DATA_WIDTH(DATA_WIDTH), .WORD_WIDTH(WORD_WIDTH)) u_b_buf (
    .clk, .rst, .clr_i(b_clr), .wr_en_i(b_wr), .wr_idx_i(beat_q), .wr_word_i(in_data),
    .ld_en_i(1'b0), .ld_data_i('0), .rd_idx_i('0), .rd_word_o(b_rd_unused), .data_o(alu_b)
  );

  wide_word_buffer #(.DATA_WIDTH(DATA_WIDTH), .WORD_WIDTH(WORD_WIDTH)) u_res_buf (
    .clk, .rst, .clr_i(1'b0), .wr_en_i(1'b0), .wr_idx_i('0), .wr_word_i('0),
    .ld_en_i(res_ld), .ld_data_i(alu_result), .rd_idx_i(beat_q), .rd_word_o(res_word),
    .data_o(res_full_unused)
  );
endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: behavioural 1-cycle ALU, table vectors, random commands,
// backpressure and mid-command reset sequences. Honours ALU_LOADER_UNARY_SKIP_EN if defined.
module tb_alu_operand_loader;
  localparam int DW = 1024;
  localparam int WW = 32;
  localparam int BEATS = DW / WW;
  localparam int LAT = 1;

  logic clk, rst;
  logic in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [2:0] in_opcode, alu_opcode;
  logic [WW-1:0] in_data, out_data;
  logic [DW-1:0] alu_a, alu_b, alu_result;

  int checks = 0;
  int errors = 0;

  alu_operand_loader #(.DATA_WIDTH(DW), .WORD_WIDTH(WW), .ALU_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU semantics: rotate amount is B mod DATA_WIDTH; opcodes 4..7 give A^B.
  function automatic logic [DW-1:0] alu_model(input logic [2:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    int s;
    s = int'(b[31:0] % DW);
    case (op)
      3'd0:    return {{(DW-1){1'b0}}, ^a};
      3'd1:    return DW'($countones(a));
      3'd2:    return (a >> s) | (a << (DW - s));
      3'd3:    return (a << s) | (a >> (DW - s));
      default: return a ^ b;
    endcase
  endfunction

  logic [DW-1:0] alu_res_q;
  always_ff @(posedge clk) alu_res_q <= alu_model(alu_opcode, alu_a, alu_b);
  assign alu_result = alu_res_q;

  function automatic bit tb_skip(input logic [2:0] op);
`ifdef ALU_LOADER_UNARY_SKIP_EN
    return op <= 3'd1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < BEATS; k++)
        if (act[k*WW +: WW] !== exp[k*WW +: WW]) begin
          $display("FAIL %s: word %0d got %h expected %h", nm, k, act[k*WW +: WW], exp[k*WW +: WW]);
          break;
        end
    end
  endtask

  // Called at #1 after a rising edge; leaves at #1 after the edge of the last accepted beat.
  task automatic send_cmd(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int gap_pct, input int limit, output int stalls);
    int nb, t;
    logic [WW-1:0] w;
    nb = tb_skip(op) ? BEATS : 2 * BEATS;
    if (limit >= 0 && limit < nb) nb = limit;
    stalls = 0;
    for (int k = 0; k < nb; k++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0; in_data = $urandom; in_opcode = 3'($urandom_range(7));
        @(posedge clk); #1;
      end
      w = (k < BEATS) ? a[k*WW +: WW] : b[(k-BEATS)*WW +: WW];
      in_valid = 1'b1; in_data = w;
      in_opcode = (k == 0) ? op : 3'($urandom_range(7));
      t = 0;
      while (!in_ready && t < 50) begin @(posedge clk); #1; t++; stalls++; end
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL send_timeout: beat %0d never accepted", k);
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Called right after the last input beat; checks latency, each beat, out_last and the hold.
  task automatic recv(input string nm, input logic [DW-1:0] exp, input int stall_pct,
                      input int hold_at, output logic [DW-1:0] got);
    int lat, i, t, held;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk({nm, "_latency"}, 64'(lat), 64'(LAT + 2));
    got = '0; i = 0; t = 0; held = 0;
    while (i < BEATS && t < 3000 && out_valid) begin
      if (i == hold_at && held < 5) out_ready = 1'b0;
      else out_ready = ($urandom_range(99) >= stall_pct);
      if (out_data !== exp[i*WW +: WW] || out_last !== (i == BEATS - 1)) begin
        chk({nm, "_beat"}, {31'(i), out_last, out_data}, {31'(i), i == BEATS - 1, exp[i*WW +: WW]});
      end else checks++;
      if (out_ready) begin got[i*WW +: WW] = out_data; i++; end
      else if (i == hold_at) held++;
      @(posedge clk); #1; t++;
    end
    out_ready = 1'b0;
    chk({nm, "_beats_drained"}, 64'(i), 64'(BEATS));
    chk({nm, "_idle_after"}, {61'd0, busy, in_ready, out_valid}, 64'b010);
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [WW-1:0] a0, a31, b0, exp0, exp31;
  } vec_t;

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    vec_t tbl[4];
    logic [DW-1:0] a, b, eb, exp, got;
    int stalls, seen;

    tbl[0] = '{3'd0, 32'h000000AC, 32'h0, 32'h000000AC, 32'h0, 32'h0};
    tbl[1] = '{3'd1, 32'h000000ED, 32'h0, 32'h0, 32'd6, 32'h0};
    tbl[2] = '{3'd2, 32'h000000AD, 32'h0, 32'd3, 32'h00000015, 32'hA0000000};
    tbl[3] = '{3'd3, 32'h0, 32'hAD000000, 32'd3, 32'h00000005, 32'h68000000};

    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("reset_ctrl", {60'd0, in_ready, out_valid, out_last, busy}, 64'b1000);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_opcode", 64'(alu_opcode), 64'd0);
    chkw("reset_alu_a", alu_a, '0);
    chkw("reset_alu_b", alu_b, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[v]) begin
      a = '0; b = '0;
      a[WW-1:0] = tbl[v].a0; a[DW-1 -: WW] = tbl[v].a31; b[WW-1:0] = tbl[v].b0;
      eb = tb_skip(tbl[v].op) ? '0 : b;
      send_cmd(tbl[v].op, a, b, 0, -1, stalls);
      chk("vec_opcode", 64'(alu_opcode), 64'(tbl[v].op));
      chkw("vec_alu_a", alu_a, a);
      chkw("vec_alu_b", alu_b, eb);
      recv("vec", alu_model(tbl[v].op, a, eb), 0, -1, got);
      chk("vec_beat0", 64'(got[WW-1:0]), 64'(tbl[v].exp0));
      chk("vec_beat31", 64'(got[DW-1 -: WW]), 64'(tbl[v].exp31));
    end

    // Backpressure: beat 7 held for five cycles, then the rest in order.
    for (int k = 0; k < BEATS; k++) begin a[k*WW +: WW] = $urandom; b[k*WW +: WW] = $urandom; end
    send_cmd(3'd2, a, b, 0, -1, stalls);
    recv("hold", alu_model(3'd2, a, b), 0, 7, got);

    // Reset after all A beats and 10 B beats: nothing may come out.
    for (int k = 0; k < BEATS; k++) begin a[k*WW +: WW] = $urandom; b[k*WW +: WW] = $urandom; end
    send_cmd(3'd2, a, b, 0, BEATS + 10, stalls);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ctrl", {60'd0, in_ready, out_valid, out_last, busy}, 64'b1000);
    chk("midrst_data_op", {29'd0, alu_opcode, out_data}, 64'd0);
    chkw("midrst_alu_a", alu_a, '0);
    chkw("midrst_alu_b", alu_b, '0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("midrst_no_output", 64'(seen), 64'd0);
    a = '0; b = '0; a[DW-1 -: WW] = 32'hAD000000; b[WW-1:0] = 32'd3;
    send_cmd(3'd3, a, b, 0, -1, stalls);
    recv("after_rst", alu_model(3'd3, a, b), 0, -1, got);
    chk("after_rst_beat0", 64'(got[WW-1:0]), 64'h5);
    chk("after_rst_beat31", 64'(got[DW-1 -: WW]), 64'h68000000);

    // POPCOUNT of all ones: beat counts depend on the unary-skip build.
    a = '1; b = '1;
`ifdef ALU_LOADER_UNARY_SKIP_EN
    send_cmd(3'd1, a, b, 0, -1, stalls);
    chk("skip_stalls", 64'(stalls), 64'd0);
    chk("skip_exec_entered", {62'd0, busy, in_ready}, 64'b10);
    chkw("skip_alu_b_zero", alu_b, '0);
    recv("skip_pop", alu_model(3'd1, a, '0), 0, -1, got);
`else
    send_cmd(3'd1, a, b, 0, BEATS, stalls);
    chk("noskip_ready_after_a", 64'(in_ready), 64'd1);
    send_cmd(3'd1, b, b, 0, BEATS, stalls);  // B half, words still accepted back-to-back
    chk("noskip_stalls", 64'(stalls), 64'd0);
    chk("noskip_ready_after_b", 64'(in_ready), 64'd0);
    recv("noskip_pop", alu_model(3'd1, a, b), 0, -1, got);
`endif
    chk("pop_all_ones_beat0", 64'(got[WW-1:0]), 64'd1024);

    // Random commands with input gaps and output stalls.
    for (int n = 0; n < 10; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(7));
      for (int k = 0; k < BEATS; k++) begin a[k*WW +: WW] = $urandom; b[k*WW +: WW] = $urandom; end
      eb = tb_skip(op) ? '0 : b;
      send_cmd(op, a, b, 20, -1, stalls);
      chk("rand_opcode", 64'(alu_opcode), 64'(op));
      chkw("rand_alu_a", alu_a, a);
      chkw("rand_alu_b", alu_b, eb);
      exp = alu_model(op, a, eb);
      recv("rand", exp, 30, -1, got);
      chkw("rand_result", got, exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Upstream/downstream wrapper for the wide ALU. It collects 1024-bit A and B operands plus a 3-bit opcode from a narrow valid/ready word stream and drives them to the ALU. After the ALU latency it captures the ALU result and streams it back out as words. It lets the wide ALU sit behind a 32-bit datapath without any software-visible width change.

## Interface
- DATA_WIDTH, 1024, width of ALU operands and result; must be a multiple of WORD_WIDTH.
- WORD_WIDTH, 32, width of stream words; BEATS = DATA_WIDTH/WORD_WIDTH (32 by default).
- ALU_LATENCY, 1, number of clock edges from operands stable at the ALU to the result being valid; 0 means combinational.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader accepts a word.
- in_opcode  in  3  opcode; sampled only on the first beat of a command.
- in_data  in  WORD_WIDTH  operand word.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts a word.
- out_data  out  WORD_WIDTH  result word.
- out_last  out  1  marks result beat BEATS-1.
- busy  out  1  command in progress (any state other than IDLE).
- alu_opcode  out  3  to ALU opcode.
- alu_a, alu_b  out  DATA_WIDTH  to ALU A_in/B_in.
- alu_result  in  DATA_WIDTH  from ALU Alu_out.

## Operation
- **Opcodes:** PARITY=000, POPCOUNT=001, ROTR=010, ROTL=011. Values 100–111 are forwarded unchanged; their result is whatever the ALU produces.
- **Beat order:** word k fills bits [k*WORD_WIDTH +: WORD_WIDTH]. Word 0 is least significant. A is sent before B.
- **IDLE:**
  - in_ready=1.
  - A handshake captures in_opcode into alu_opcode and in_data into A word 0, then goes to LOAD_A.
- **LOAD_A:**
  - Accepts A words 1..BEATS-1.
  - After the last A word, goes to LOAD_B, or to EXEC when the unary skip applies (see Configuration).
- **LOAD_B:** accepts B words 0..BEATS-1. After the last B word, goes to EXEC.
- **EXEC:**
  - in_ready=0.
  - Counter cnt starts at 0 and increments each cycle.
  - alu_result is captured into the result register on the edge ending the cycle with cnt==ALU_LATENCY, then the state goes to DRAIN.
- **DRAIN:**
  - out_valid=1; out_data = result word at beat index.
  - The index advances only on an out_valid&&out_ready handshake.
  - out_last=1 when index==BEATS-1.
  - The handshake on the last beat returns the block to IDLE.
- **Output stability:** alu_opcode, alu_a and alu_b change only on input handshakes. They are held from the last input beat until the next command's first beat.
- **Backpressure:**
  - out_data and out_last are held stable while out_valid&&!out_ready.
  - in_valid is ignored whenever in_ready=0.
- **Reset:**
  - state=IDLE, in_ready=1.
  - out_valid=0, out_data=0, out_last=0, busy=0.
  - alu_opcode=0, alu_a=0, alu_b=0; result register, beat counters and cnt all 0.
- **Reset mid-operation:** any partial operands or undrained result are discarded and nothing is emitted. The next command starts cleanly from IDLE.

## Timing
- A command takes 2*BEATS input cycles at full rate (BEATS when skipped).
- The final input handshake is at edge N. The state is EXEC from N; capture happens at edge N+ALU_LATENCY+1. out_valid first rises in the cycle after capture, i.e. ALU_LATENCY+2 cycles after the last input beat.
- The result drains in BEATS cycles when out_ready is held high.
- The first beat of the next command is accepted in the cycle after the last output handshake. There is no overlap between commands.
- in_ready and out_valid are decodes of the state register only. There is no combinational path from in_valid or out_ready.

## Configuration
- **With ALU_LOADER_UNARY_SKIP_EN defined:**
  - PARITY and POPCOUNT commands carry A beats only.
  - LOAD_B is bypassed and alu_b is driven to all zeros for that command.
- **Without the macro:** every opcode takes BEATS A beats followed by BEATS B beats.

## Structure
- **Shared package alu_pkg:**
  - Opcode localparams PARITY, POPCOUNT, ROTR, ROTL.
  - FSM state encoding IDLE/LOAD_A/LOAD_B/EXEC/DRAIN.
  - Default DATA_WIDTH/WORD_WIDTH constants.
- **Sub-module wide_word_buffer:** a DATA_WIDTH register with an indexed WORD_WIDTH write and indexed read. It is instantiated for A, B and result; result uses the full-width parallel load.

## Test plan
All scenarios use defaults and a behavioural ALU with ALU_LATENCY=1.
- PARITY, A word0=0x000000AC, B word0=0x000000AC, other words 0 -> alu_opcode=000, alu_a[7:0]=0xAC, out beat0=0, beats 1..31=0, out_last only on beat 31.
- POPCOUNT, A word0=0x000000ED -> out beat0=6. out_valid first rises 3 cycles after the last input beat.
- ROTR, A word0=0xAD, B word0=3 -> alu_b[7:0]=3, out beat0=0x00000015, beat31=0xA0000000.
- out_ready low for 5 cycles while beat 7 is presented -> out_data, out_last and the beat index are held; beats 8..31 then follow in order.
- rst pulsed after 10 B beats -> all outputs at reset values immediately, no out_valid. A following ROTL with A word31=0xAD000000, B=3 yields beat0=0x00000005, beat31=0x68000000.
- POPCOUNT A=all ones:
  - With ALU_LOADER_UNARY_SKIP_EN: EXEC entered after 32 input beats, alu_b=0, result beat0=1024.
  - Without the macro: in_ready stays high for 64 beats.
